// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus: active-low request/grant per master,
// back-to-back handover with no preemption, and a one-shot flag when a tenure runs too long.
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2,
  parameter int HOLD_LIMIT  = 256,
  parameter int CNT_W       = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req_,
  output logic [NUM_MASTERS-1:0] grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   bus_busy,
  output logic                   hold_err
);

  typedef enum logic {IDLE, GRANTED} state_t;

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(HOLD_LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(HOLD_LIMIT - 1);

  state_t                   state;
  logic [CNT_W-1:0]         hold_cnt;
  logic [NUM_MASTERS-1:0]   req, cand;
  logic                     owner_req, win_vld;
  logic [OWNER_W-1:0]       win;

  assign req       = ~req_;
  assign owner_req = req[owner];

  // The releasing owner is masked out, so it only competes again from the next
  // edge, and then as the last candidate in the scan.
  always_comb begin
    cand    = req;
    win     = '0;
    win_vld = 1'b0;
    if (state == GRANTED) cand[owner] = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      int idx;
      idx = (int'(owner) + i) % NUM_MASTERS;
      if (!win_vld && cand[idx[OWNER_W-1:0]]) begin
        win_vld = 1'b1;
        win     = OWNER_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grnt_    <= '1;
      owner    <= '0;
      bus_busy <= 1'b0;
      hold_err <= 1'b0;
      hold_cnt <= '0;
    end else begin
      hold_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= GRANTED;
            owner    <= win;
            grnt_    <= ~(NUM_MASTERS'(1) << win);
            bus_busy <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANTED: begin
          if (owner_req) begin
            // Saturating at the limit makes the pulse one-shot per tenure.
            if (HOLD_LIMIT != 0 && hold_cnt != LIM) begin
              hold_cnt <= hold_cnt + CNT_W'(1);
              if (hold_cnt == LIM_M1) hold_err <= 1'b1;
            end
          end else if (win_vld) begin
            owner    <= win;
            grnt_    <= ~(NUM_MASTERS'(1) << win);
            hold_cnt <= '0;
          end else begin
            state    <= IDLE;
            grnt_    <= '1;
            bus_busy <= 1'b0;
            hold_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected outputs queued as each step is driven,
// popped and compared one time unit after the following clock edge.
module tb_bus_arbiter;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_  = 4'b1111;
  logic [3:0] grnt_, grnt0_;
  logic [1:0] owner, owner0;
  logic       bus_busy, busy0, hold_err, err0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    logic       e;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(4), .OWNER_W(2), .HOLD_LIMIT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_(req_), .grnt_(grnt_),
    .owner(owner), .bus_busy(bus_busy), .hold_err(hold_err)
  );

  bus_arbiter #(.NUM_MASTERS(4), .OWNER_W(2), .HOLD_LIMIT(0), .CNT_W(1)) dut0 (
    .clk(clk), .reset(reset), .req_(req_), .grnt_(grnt0_),
    .owner(owner0), .bus_busy(busy0), .hold_err(err0)
  );

  task automatic cyc(input string tag, input logic rst, input logic [3:0] r,
                     input logic [3:0] g, input logic [1:0] o, input logic b, input logic e);
    obs_t got, want;
    reset = rst;
    req_  = r;
    exp_q.push_back(obs_t'({g, o, b, e}));
    @(posedge clk);
    #1;
    got  = obs_t'({grnt_, owner, bus_busy, hold_err});
    want = exp_q.pop_front();
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got grnt_=%b owner=%0d busy=%b err=%b, want grnt_=%b owner=%0d busy=%b err=%b",
             tag, got.g, got.o, got.b, got.e, want.g, want.o, want.b, want.e);
    end
    vectors++;
    assert (err0 === 1'b0) else begin
      miscompares++;
      $error("FAIL %s_limit0: got hold_err=%b, want 0", tag, err0);
    end
  endtask

  initial begin
    logic [3:0] r, g;
    int k, n;

    cyc("reset",     1, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0);
    cyc("reset",     1, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0);
    cyc("idle",      0, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0);

    cyc("t1_grant",  0, 4'b1011, 4'b1011, 2'd2, 1'b1, 1'b0);
    cyc("t1_hold",   0, 4'b1011, 4'b1011, 2'd2, 1'b1, 1'b0);

    cyc("t3_release",0, 4'b1111, 4'b1111, 2'd2, 1'b0, 1'b0);
    cyc("t3_scan",   0, 4'b1010, 4'b1110, 2'd0, 1'b1, 1'b0);

    // Owner 0 drops while 2 requests; 0 asks again and must wait for 2.
    cyc("t6_handover",0, 4'b1011, 4'b1011, 2'd2, 1'b1, 1'b0);
    cyc("t6_hold",   0, 4'b1010, 4'b1011, 2'd2, 1'b1, 1'b0);
    cyc("t6_hold",   0, 4'b1010, 4'b1011, 2'd2, 1'b1, 1'b0);
    cyc("t6_regain", 0, 4'b1110, 4'b1110, 2'd0, 1'b1, 1'b0);

    cyc("t2_idle",   0, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0);
    cyc("t2_first",  0, 4'b0000, 4'b1101, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      k = (i + 1) % 4;
      n = (k + 1) % 4;
      g = 4'b1111 ^ (4'b0001 << k);
      cyc("t2_hold", 0, 4'b0000, g, 2'(k), 1'b1, 1'b0);
      cyc("t2_hold", 0, 4'b0000, g, 2'(k), 1'b1, 1'b0);
      r = 4'b0001 << k;
      g = 4'b1111 ^ (4'b0001 << n);
      cyc("t2_handover", 0, r, g, 2'(n), 1'b1, 1'b0);
    end
    cyc("t2_idle2",  0, 4'b1111, 4'b1111, 2'd1, 1'b0, 1'b0);

    cyc("t4_grant",  0, 4'b1101, 4'b1101, 2'd1, 1'b1, 1'b0);
    for (int j = 1; j <= 20; j++)
      cyc("t4_hold", 0, 4'b1101, 4'b1101, 2'd1, 1'b1, (j == 8));
    cyc("t4_release",0, 4'b1111, 4'b1111, 2'd1, 1'b0, 1'b0);

    cyc("t5_grant",  0, 4'b0111, 4'b0111, 2'd3, 1'b1, 1'b0);
    cyc("t5_hold",   0, 4'b0111, 4'b0111, 2'd3, 1'b1, 1'b0);
    cyc("t5_reset",  1, 4'b0110, 4'b1111, 2'd0, 1'b0, 1'b0);
    cyc("t5_rearb",  0, 4'b0110, 4'b0111, 2'd3, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
